// File: rtl/frame_draw_sequencer.sv
// Frame-rate erase/shift/latch/draw scheduler that owns the single VGA plot port.
// Optional build macro FRAME_DRAW_BORDER_EN: outline the drawn block in ~FG_COLOUR.
module frame_draw_sequencer #(
    parameter int         BLOCK_W   = 16,
    parameter int         BLOCK_H   = 16,
    parameter int         SCR_W     = 160,
    parameter int         SCR_H     = 120,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       pause,
    input  logic       clear_req,
    input  logic       redraw_req,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    output logic       shift_en,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done,
    output logic [7:0] overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ERASE,
        S_SHIFT,
        S_LATCH,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [7:0] L_SCR_X_LAST = 8'(SCR_W - 1);
    localparam logic [6:0] L_SCR_Y_LAST = 7'(SCR_H - 1);
    localparam logic [7:0] L_BLK_X_LAST = 8'(BLOCK_W - 1);
    localparam logic [6:0] L_BLK_Y_LAST = 7'(BLOCK_H - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_px;
    logic [6:0] r_py;
    logic [7:0] w_px_next;
    logic [6:0] w_py_next;
    logic [7:0] w_x_last;
    logic [6:0] w_y_last;
    logic [7:0] r_base_x;
    logic [6:0] r_base_y;
    logic       r_pending;
    logic [7:0] r_overrun;
    logic       w_go;
    logic       w_tick_ok;
    logic       w_accept_clear;
    logic       w_accept_redraw;
    logic       w_accept_frame;
`ifdef FRAME_DRAW_BORDER_EN
    logic       w_edge;
`endif

    assign w_go      = run & ~pause;
    assign w_tick_ok = frame_tick & w_go;
    assign overrun   = r_overrun;

`ifdef FRAME_DRAW_BORDER_EN
    assign w_edge = (r_px == 8'd0) || (r_px == L_BLK_X_LAST) ||
                    (r_py == 7'd0) || (r_py == L_BLK_Y_LAST);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_px      <= 8'd0;
            r_py      <= 7'd0;
            r_base_x  <= 8'd0;
            r_base_y  <= 7'd0;
            r_pending <= 1'b0;
            r_overrun <= 8'd0;
        end else begin
            r_state <= w_next;
            r_px    <= w_px_next;
            r_py    <= w_py_next;
            if (r_state == S_LATCH) begin
                r_base_x <= x_in;
                r_base_y <= y_in;
            end
            // In IDLE a tick either starts the job, rides along as pending behind a request, or is discarded
            if (r_state == S_IDLE) begin
                if (w_accept_clear) begin
                    r_overrun <= 8'd0;
                    r_pending <= w_tick_ok;
                end else if (w_accept_redraw) begin
                    r_pending <= r_pending | w_tick_ok;
                end else if (w_accept_frame) begin
                    r_pending <= 1'b0;
                end
            end else if (frame_tick) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_overrun != 8'hFF) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        w_px_next       = r_px;
        w_py_next       = r_py;
        w_x_last        = (r_state == S_CLEAR) ? L_SCR_X_LAST : L_BLK_X_LAST;
        w_y_last        = (r_state == S_CLEAR) ? L_SCR_Y_LAST : L_BLK_Y_LAST;
        w_accept_clear  = 1'b0;
        w_accept_redraw = 1'b0;
        w_accept_frame  = 1'b0;
        plot            = 1'b0;
        shift_en        = 1'b0;
        done            = 1'b0;
        busy            = (r_state != S_IDLE);
        vga_x           = 8'd0;
        vga_y           = 7'd0;
        colour          = BG_COLOUR;

        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_next         = S_CLEAR;
                    w_accept_clear = 1'b1;
                end else if (redraw_req) begin
                    w_next          = S_LATCH;
                    w_accept_redraw = 1'b1;
                end else if ((frame_tick || r_pending) && w_go) begin
                    w_next         = S_ERASE;
                    w_accept_frame = 1'b1;
                end
            end
            S_CLEAR, S_ERASE, S_DRAW: begin
                plot = 1'b1;
                if (r_state == S_CLEAR) begin
                    vga_x = r_px;
                    vga_y = r_py;
                end else begin
                    vga_x = r_base_x + r_px;
                    vga_y = r_base_y + r_py;
                end
                if (r_state == S_DRAW) begin
`ifdef FRAME_DRAW_BORDER_EN
                    colour = w_edge ? ~FG_COLOUR : FG_COLOUR;
`else
                    colour = FG_COLOUR;
`endif
                end
                // Raster sweep, x fastest; both counters return to zero when the sweep ends
                if (r_px == w_x_last) begin
                    w_px_next = 8'd0;
                    if (r_py == w_y_last) begin
                        w_py_next = 7'd0;
                        w_next    = (r_state == S_ERASE) ? S_SHIFT : S_DONE;
                    end else begin
                        w_py_next = r_py + 7'd1;
                    end
                end else begin
                    w_px_next = r_px + 8'd1;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                w_next   = S_LATCH;
            end
            S_LATCH: begin
                w_next = S_DRAW;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Self-checking bench for frame_draw_sequencer: expected plot streams are built from
// whole-job descriptions (clear sweep, block erase/draw) and compared cycle by cycle.
module tb_frame_draw_sequencer;

    localparam int         W  = 16;
    localparam int         H  = 16;
    localparam int         SW = 160;
    localparam int         SH = 120;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       run = 1'b0;
    logic       pause = 1'b0;
    logic       clear_req = 1'b0;
    logic       redraw_req = 1'b0;
    logic [7:0] x_in = 8'd0;
    logic [6:0] y_in = 7'd0;
    logic       shift_en;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       busy;
    logic       done;
    logic [7:0] overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       plot;
        logic       shift;
        logic       busy;
        logic       done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } obs_t;

    obs_t q[$];

    always #5 clk = ~clk;

    frame_draw_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .run        (run),
        .pause      (pause),
        .clear_req  (clear_req),
        .redraw_req (redraw_req),
        .x_in       (x_in),
        .y_in       (y_in),
        .shift_en   (shift_en),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: job-level expected streams ----------------
    function automatic obs_t pix(input int x, input int y, input logic [2:0] c);
        obs_t o;
        o.plot  = 1'b1;
        o.shift = 1'b0;
        o.busy  = 1'b1;
        o.done  = 1'b0;
        o.x     = 8'(x);
        o.y     = 7'(y);
        o.c     = c;
        return o;
    endfunction

    function automatic obs_t ctl(input logic sh, input logic bz, input logic dn);
        obs_t o;
        o.plot  = 1'b0;
        o.shift = sh;
        o.busy  = bz;
        o.done  = dn;
        o.x     = 8'd0;
        o.y     = 7'd0;
        o.c     = BG;
        return o;
    endfunction

    function automatic logic [2:0] draw_colour(input int px, input int py);
`ifdef FRAME_DRAW_BORDER_EN
        if (px == 0 || px == W - 1 || py == 0 || py == H - 1) return ~FG;
`endif
        return FG;
    endfunction

    task automatic add_block(input int bx, input int by, input bit is_draw);
        for (int py = 0; py < H; py++)
            for (int px = 0; px < W; px++)
                q.push_back(pix(bx + px, by + py, is_draw ? draw_colour(px, py) : BG));
    endtask

    task automatic add_clear();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                q.push_back(pix(x, y, BG));
        q.push_back(ctl(1'b0, 1'b1, 1'b1));
    endtask

    task automatic add_redraw(input int bx, input int by);
        q.push_back(ctl(1'b0, 1'b1, 1'b0));
        add_block(bx, by, 1'b1);
        q.push_back(ctl(1'b0, 1'b1, 1'b1));
    endtask

    task automatic add_frame(input int ebx, input int eby, input int dbx, input int dby);
        add_block(ebx, eby, 1'b0);
        q.push_back(ctl(1'b1, 1'b1, 1'b0));
        q.push_back(ctl(1'b0, 1'b1, 1'b0));
        add_block(dbx, dby, 1'b1);
        q.push_back(ctl(1'b0, 1'b1, 1'b1));
    endtask

    // Steps through q one cycle per entry; datapath x_in advances on each observed shift_en.
    task automatic run_stream(output int bad, output int first_idx, output obs_t fgot, output obs_t fexp);
        obs_t g;
        obs_t e;
        bit   ok;
        bad = 0;
        first_idx = -1;
        fgot = '0;
        fexp = '0;
        for (int i = 0; i < q.size(); i++) begin
            g.plot  = plot;
            g.shift = shift_en;
            g.busy  = busy;
            g.done  = done;
            g.x     = vga_x;
            g.y     = vga_y;
            g.c     = colour;
            e = q[i];
            ok = (g.plot === e.plot) && (g.shift === e.shift) &&
                 (g.busy === e.busy) && (g.done === e.done);
            if (e.plot) ok = ok && (g.x === e.x) && (g.y === e.y) && (g.c === e.c);
            if (!ok) begin
                if (bad == 0) begin
                    first_idx = i;
                    fgot = g;
                    fexp = e;
                end
                bad++;
            end
            if (shift_en === 1'b1) x_in = x_in + 8'd1;
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic pulse(input bit c, input bit r, input bit t);
        clear_req  = c;
        redraw_req = r;
        frame_tick = t;
        @(negedge clk);
        clear_req  = 1'b0;
        redraw_req = 1'b0;
        frame_tick = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({plot, shift_en, done, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {plot, shift_en, done, busy});
        end
        n_checks++;
        if ({vga_x, vga_y} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_xy: got x=%0d y=%0d expected 0,0", vga_x, vga_y);
        end
        n_checks++;
        if (colour !== BG || overrun !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_colour_overrun: got %b/%0d expected %b/0", colour, overrun, BG);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_clear();
        int bad, idx;
        obs_t g, e;
        pulse(1'b1, 1'b0, 1'b0);
        add_clear();
        run_stream(bad, idx, g, e);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL clear_stream: %0d bad cycles, first %0d got %h expected %h", bad, idx, g, e);
        end
        n_checks++;
        if (overrun !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_end: overrun/busy got %0d/%b expected 0/0", overrun, busy);
        end
    endtask

    task automatic test_frame();
        int bad, idx, bx, by;
        obs_t g, e;
        run = 1'b1;
        pause = 1'b0;
        for (int it = 0; it < 4; it++) begin
            bx = (it == 0) ? 0 : int'($urandom_range(0, SW - W - 1));
            by = (it == 0) ? 104 : int'($urandom_range(0, SH - H));
            x_in = 8'(bx);
            y_in = 7'(by);
            pulse(1'b0, 1'b1, 1'b0);
            add_redraw(bx, by);
            run_stream(bad, idx, g, e);
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL redraw_stream[%0d]: %0d bad, first %0d got %h expected %h", it, bad, idx, g, e);
            end
            pulse(1'b0, 1'b0, 1'b1);
            add_frame(bx, by, bx + 1, by);
            run_stream(bad, idx, g, e);
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL frame_stream[%0d]: %0d bad, first %0d got %h expected %h", it, bad, idx, g, e);
            end
            n_checks++;
            if (x_in !== 8'(bx + 1)) begin
                n_fail++;
                $display("FAIL frame_shift_count[%0d]: x_in got %0d expected %0d", it, x_in, bx + 1);
            end
        end
    endtask

    task automatic test_gating();
        int activity;
        for (int mode = 0; mode < 2; mode++) begin
            run   = (mode == 1);
            pause = (mode == 1);
            activity = 0;
            for (int k = 0; k < 3; k++) begin
                pulse(1'b0, 1'b0, 1'b1);
                repeat (4) begin
                    if (plot !== 1'b0 || shift_en !== 1'b0 || busy !== 1'b0) activity++;
                    @(negedge clk);
                end
            end
            n_checks++;
            if (activity !== 0) begin
                n_fail++;
                $display("FAIL gating_activity[%0d]: got %0d active cycles expected 0", mode, activity);
            end
            n_checks++;
            if (overrun !== 8'd0) begin
                n_fail++;
                $display("FAIL gating_overrun[%0d]: got %0d expected 0", mode, overrun);
            end
        end
        run = 1'b1;
        pause = 1'b0;
        activity = 0;
        repeat (10) begin
            if (busy !== 1'b0) activity++;
            @(negedge clk);
        end
        n_checks++;
        if (activity !== 0) begin
            n_fail++;
            $display("FAIL gating_no_pending: got %0d busy cycles expected 0", activity);
        end
    endtask

    task automatic test_simultaneous();
        int bad, idx;
        obs_t g, e;
        run = 1'b1;
        pause = 1'b0;
        x_in = 8'd20;
        y_in = 7'd30;
        pulse(1'b0, 1'b1, 1'b1);
        add_redraw(20, 30);
        q.push_back(ctl(1'b0, 1'b0, 1'b0));
        add_frame(20, 30, 21, 30);
        run_stream(bad, idx, g, e);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL simultaneous_stream: %0d bad, first %0d got %h expected %h", bad, idx, g, e);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, cy, t_done, dones;
        run = 1'b1;
        pause = 1'b0;
        d1 = int'($urandom_range(3, 200));
        d2 = int'($urandom_range(d1 + 2, 500));
        pulse(1'b0, 1'b0, 1'b1);
        cy = 0;
        t_done = -1;
        while (cy < 2000 && t_done < 0) begin
            frame_tick = (cy == d1 || cy == d2);
            if (done === 1'b1) t_done = cy;
            @(negedge clk);
            cy++;
        end
        frame_tick = 1'b0;
        n_checks++;
        if (t_done !== 514) begin
            n_fail++;
            $display("FAIL job_latency: done at cycle %0d expected 514", t_done);
        end
        n_checks++;
        if ({busy, plot} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_between_jobs: busy/plot got %b expected 00", {busy, plot});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, plot} !== 2'b11) begin
            n_fail++;
            $display("FAIL pending_job_start: busy/plot got %b expected 11", {busy, plot});
        end
        n_checks++;
        if (overrun !== 8'd1) begin
            n_fail++;
            $display("FAIL overrun_one: got %0d expected 1", overrun);
        end
        cy = 0;
        while (cy < 1000 && done !== 1'b1) begin
            @(negedge clk);
            cy++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_job_done: done got %b expected 1 within 1000 cycles", done);
        end
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
        end
        frame_tick = 1'b0;
        n_checks++;
        if (overrun !== 8'd255) begin
            n_fail++;
            $display("FAIL overrun_saturate: got %0d expected 255", overrun);
        end
        dones = 0;
        cy = 0;
        while (cy < 3000 && dones < 2) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
            cy++;
        end
        n_checks++;
        if (dones !== 2 || overrun !== 8'd255) begin
            n_fail++;
            $display("FAIL drain_jobs: dones/overrun got %0d/%0d expected 2/255", dones, overrun);
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 8'd0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %0d expected 0", overrun);
        end
        cy = 0;
        while (cy < 20000 && done !== 1'b1) begin
            @(negedge clk);
            cy++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_done_bound: done got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_draw();
        int bad, idx, cnt, cy;
        obs_t g, e;
        run = 1'b1;
        pause = 1'b0;
        x_in = 8'd40;
        y_in = 7'd50;
        pulse(1'b0, 1'b1, 1'b0);
        add_redraw(40, 50);
        run_stream(bad, idx, g, e);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mid_redraw_stream: %0d bad, first %0d got %h expected %h", bad, idx, g, e);
        end
        pulse(1'b0, 1'b0, 1'b1);
        cnt = 0;
        cy = 0;
        while (cy < 1000) begin
            if (plot === 1'b1) cnt++;
            if (cnt == W * H + 100) break;
            if (shift_en === 1'b1) x_in = x_in + 8'd1;
            @(negedge clk);
            cy++;
        end
        n_checks++;
        if (cnt !== W * H + 100) begin
            n_fail++;
            $display("FAIL reach_draw_100: plot count got %0d expected %0d", cnt, W * H + 100);
        end
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({plot, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_draw: plot/busy got %b expected 00", {plot, busy});
        end
        resetn = 1'b1;
        x_in = 8'd3;
        y_in = 7'd7;
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        add_frame(0, 0, 4, 7);
        run_stream(bad, idx, g, e);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL post_reset_frame: %0d bad, first %0d got %h expected %h", bad, idx, g, e);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_frame();
        test_gating();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
